// File: rtl/core_host_sequencer_pkg.sv
// Shared op codes, image size and FSM state encoding for the host-side
// sequencer of the image-processing core.
package core_host_sequencer_pkg;

  localparam int unsigned IMG_BYTES = 2048;

  localparam logic [3:0] OP_LOAD      = 4'd0;
  localparam logic [3:0] OP_DISPLAY   = 4'd7;
  localparam logic [3:0] OP_CONV      = 4'd8;
  localparam logic [3:0] OP_MEDIAN    = 4'd9;
  localparam logic [3:0] OP_SOBEL_NMS = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LOAD,
    S_RUN,
    S_ERR
  } state_t;

  // Codes above SOBEL_NMS are consumed from upstream but never issued.
  function automatic logic is_valid_op(input logic [3:0] mode);
    return mode <= OP_SOBEL_NMS;
  endfunction

endpackage

// File: rtl/core_host_sequencer_fifo.sv
// Two-entry prefetch FIFO for the LOAD stream; tracks the single outstanding
// memory read so that buffered plus in-flight bytes never exceed two.
module prefetch_fifo2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       flush,
  input  logic       fetch_req,
  output logic       fetch_go,
  input  logic [7:0] rdata,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data
);

  logic [1:0] occ;
  logic       in_flight;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [7:0] mem [2];
  logic       push;
  logic       pop;
  logic [1:0] committed;

  assign committed = occ + {1'b0, in_flight};
  assign valid     = !flush && (occ != 2'd0);
  assign data      = mem[rd_ptr];
  assign pop       = valid && ready;
  assign push      = in_flight && !flush;
  // A pop this cycle frees a slot, letting the refill overlap it for 1 byte/cycle.
  assign fetch_go  = fetch_req && !flush && ((committed < 2'd2) || pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values
  // independent of statement order inside the block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ       <= 2'd0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      // NOTE: this storage is reset only because its head drives an output
      // port that must read 0 out of reset; FIFO RAM is normally left unreset.
      mem[0]    <= 8'd0;
      mem[1]    <= 8'd0;
    end else if (flush) begin
      occ       <= 2'd0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      in_flight <= fetch_go;
      if (push) begin
        mem[wr_ptr] <= rdata;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/core_host_sequencer.sv
// Host-side initiator: answers core op-ready pulses with queued commands,
// streams the image on LOAD and forwards tagged results.
module core_host_sequencer #(
  parameter int unsigned IMG_BYTES      = core_host_sequencer_pkg::IMG_BYTES,
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  input  logic [3:0]        i_cmd_mode,
  output logic              o_cmd_ready,
  output logic              o_img_ren,
  output logic [ADDR_W-1:0] o_img_addr,
  input  logic [7:0]        i_img_rdata,
  input  logic              i_op_ready,
  output logic              o_op_valid,
  output logic [3:0]        o_op_mode,
  input  logic              i_in_ready,
  output logic              o_in_valid,
  output logic [7:0]        o_in_data,
  input  logic              i_out_valid,
  input  logic [13:0]       i_out_data,
  output logic              o_res_valid,
  output logic [13:0]       o_res_data,
  output logic [3:0]        o_res_mode,
  output logic [CNT_W-1:0]  o_res_count,
  output logic              o_busy,
  output logic              o_timeout
);

  import core_host_sequencer_pkg::*;

  localparam int unsigned     TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0] IMG_TOTAL = (ADDR_W + 1)'(IMG_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic              pending;
  logic [3:0]        mode_q;
  logic [ADDR_W:0]   rd_addr;
  logic [ADDR_W:0]   xfer_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic cmd_take;
  logic cmd_issue;
  logic op_issue;
  logic in_load;
  logic fetch_req;
  logic fetch_go;
  logic xfer;
  logic last_xfer;
  logic tmo_active;
  logic tmo_kick;
  logic tmo_hit;

  assign o_cmd_ready = (state == S_IDLE) && pending;
  assign cmd_take    = i_cmd_valid && o_cmd_ready;
  assign cmd_issue   = cmd_take && is_valid_op(i_cmd_mode);
  assign op_issue    = (state == S_ISSUE);
  assign o_op_valid  = op_issue;
  assign o_op_mode   = op_issue ? mode_q : 4'd0;
  assign o_busy      = (state == S_ISSUE) || (state == S_LOAD) || (state == S_RUN);

  assign in_load    = (state == S_LOAD);
  assign fetch_req  = in_load && (rd_addr < IMG_TOTAL);
  assign o_img_ren  = fetch_go;
  assign o_img_addr = rd_addr[ADDR_W-1:0];
  assign xfer       = o_in_valid && i_in_ready;
  assign last_xfer  = xfer && (xfer_cnt == IMG_TOTAL - 1'b1);

  // Any sign of life from the core, or a delivered load byte, restarts the watchdog.
  assign tmo_active = in_load || (state == S_RUN);
  assign tmo_kick   = i_op_ready || i_out_valid || xfer;
  assign tmo_hit    = tmo_active && !tmo_kick && (tmo_cnt == TMO_LAST);

  prefetch_fifo2 u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .flush     (!in_load),
    .fetch_req (fetch_req),
    .fetch_go  (fetch_go),
    .rdata     (i_img_rdata),
    .ready     (i_in_ready),
    .valid     (o_in_valid),
    .data      (o_in_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: next state is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_issue) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (mode_q == OP_LOAD) ? S_LOAD : S_RUN;
      S_LOAD: begin
        if (tmo_hit)        state_nxt = S_ERR;
        else if (last_xfer) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_op_ready)   state_nxt = S_IDLE;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending   <= 1'b0;
      mode_q    <= 4'd0;
      rd_addr   <= '0;
      xfer_cnt  <= '0;
      tmo_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      // A fresh op-ready pulse outranks the clear from the issue it answers.
      if (i_op_ready) begin
        pending <= 1'b1;
      end else if (op_issue) begin
        pending <= 1'b0;
      end

      if (cmd_issue) begin
        mode_q <= i_cmd_mode;
      end

      if (op_issue) begin
        rd_addr <= '0;
      end else if (fetch_go) begin
        rd_addr <= rd_addr + 1'b1;
      end

      if (op_issue) begin
        xfer_cnt <= '0;
      end else if (xfer) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end

      if (!tmo_active || tmo_kick) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (tmo_hit) begin
        o_timeout <= 1'b1;
      end
    end
  end

  // Results are forwarded in every state, tagged with the last issued op.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_res_valid <= 1'b0;
      o_res_data  <= 14'd0;
      o_res_mode  <= 4'd0;
      o_res_count <= '0;
    end else begin
      o_res_valid <= i_out_valid;
      if (i_out_valid) begin
        o_res_data <= i_out_data;
        o_res_mode <= mode_q;
      end
      if (op_issue) begin
        o_res_count <= {{(CNT_W-1){1'b0}}, i_out_valid};
      end else if (i_out_valid && (o_res_count != {CNT_W{1'b1}})) begin
        o_res_count <= o_res_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_host_sequencer.sv
// Scoreboard bench for core_host_sequencer: a driver pushes expected ops,
// load bytes and results; a negedge monitor pops and compares them.
module tb_core_host_sequencer;

  import core_host_sequencer_pkg::*;

  localparam int unsigned IMG_N  = 2048;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned TMO    = 100;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              i_rst_n;
  logic              i_cmd_valid;
  logic [3:0]        i_cmd_mode;
  logic              o_cmd_ready;
  logic              o_img_ren;
  logic [ADDR_W-1:0] o_img_addr;
  logic [7:0]        i_img_rdata;
  logic              i_op_ready;
  logic              o_op_valid;
  logic [3:0]        o_op_mode;
  logic              i_in_ready;
  logic              o_in_valid;
  logic [7:0]        o_in_data;
  logic              i_out_valid;
  logic [13:0]       i_out_data;
  logic              o_res_valid;
  logic [13:0]       o_res_data;
  logic [3:0]        o_res_mode;
  logic [CNT_W-1:0]  o_res_count;
  logic              o_busy;
  logic              o_timeout;

  core_host_sequencer #(
    .IMG_BYTES      (IMG_N),
    .ADDR_W         (ADDR_W),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_mode  (i_cmd_mode),
    .o_cmd_ready (o_cmd_ready),
    .o_img_ren   (o_img_ren),
    .o_img_addr  (o_img_addr),
    .i_img_rdata (i_img_rdata),
    .i_op_ready  (i_op_ready),
    .o_op_valid  (o_op_valid),
    .o_op_mode   (o_op_mode),
    .i_in_ready  (i_in_ready),
    .o_in_valid  (o_in_valid),
    .o_in_data   (o_in_data),
    .i_out_valid (i_out_valid),
    .i_out_data  (i_out_data),
    .o_res_valid (o_res_valid),
    .o_res_data  (o_res_data),
    .o_res_mode  (o_res_mode),
    .o_res_count (o_res_count),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Image memory: data valid exactly one cycle after the read, garbage otherwise.
  logic [7:0] rom [IMG_N];
  always @(posedge clk) i_img_rdata <= o_img_ren ? rom[o_img_addr] : 8'($urandom);

  bit rand_ready = 1'b0;
  initial begin
    i_in_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_in_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct { logic [3:0] mode; int at; } op_exp_t;
  typedef struct { logic [13:0] data; logic [3:0] mode; logic [CNT_W-1:0] cnt; int at; } res_exp_t;

  op_exp_t    op_q [$];
  logic [7:0] byte_q [$];
  res_exp_t   res_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: owns all scoreboard bookkeeping except the pushes.
  int         exp_addr = 0;
  int         first_x = -1;
  int         last_x = -1;
  bit         stalled = 1'b0;
  logic [7:0] held;
  op_exp_t    eo;
  res_exp_t   er;
  logic [7:0] eb;

  always @(negedge clk) begin
    if (!i_rst_n) begin
      op_q.delete();
      byte_q.delete();
      res_q.delete();
      exp_addr = 0;
      stalled  = 1'b0;
    end else begin
      if (o_op_valid) begin
        if (op_q.size() == 0) check("unexpected_op", 32'd1, 32'd0);
        else begin
          eo = op_q.pop_front();
          check("op_mode", 32'(o_op_mode), 32'(eo.mode));
          check("op_cycle", cyc, eo.at);
          if (eo.mode == OP_LOAD) begin
            exp_addr = 0;
            first_x  = -1;
          end
        end
      end
      if (o_img_ren) begin
        check("img_addr", 32'(o_img_addr), 32'(exp_addr));
        exp_addr++;
      end
      if (stalled) begin
        check("stall_valid", 32'(o_in_valid), 32'd1);
        check("stall_data", 32'(o_in_data), 32'(held));
      end
      if (o_in_valid && i_in_ready) begin
        if (byte_q.size() == 0) check("extra_byte", 32'd1, 32'd0);
        else begin
          eb = byte_q.pop_front();
          check("in_data", 32'(o_in_data), 32'(eb));
        end
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      stalled = o_in_valid && !i_in_ready;
      held    = o_in_data;
      if (o_res_valid) begin
        if (res_q.size() == 0) check("unexpected_res", 32'd1, 32'd0);
        else begin
          er = res_q.pop_front();
          check("res_data", 32'(o_res_data), 32'(er.data));
          check("res_mode", 32'(o_res_mode), 32'(er.mode));
          check("res_count", 32'(o_res_count), 32'(er.cnt));
          check("res_cycle", cyc, er.at);
        end
      end
    end
  end

  // Reference model of the op in flight: last issued mode and its result tally.
  logic [3:0] m_mode = 4'd0;
  int         m_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_op_ready();
    i_op_ready = 1'b1;
    tick();
    i_op_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] mode);
    int n = 0;
    while (!o_cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      check("cmd_ready_wait", 32'd0, 32'd1);
      return;
    end
    i_cmd_valid = 1'b1;
    i_cmd_mode  = mode;
    if (mode <= OP_SOBEL_NMS) begin
      op_q.push_back('{mode: mode, at: cyc + 1});
      m_mode = mode;
      m_cnt  = 0;
      if (mode == OP_LOAD) begin
        for (int i = 0; i < IMG_N; i++) byte_q.push_back(rom[i]);
      end
    end
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_mode  = 4'($urandom);
  endtask

  task automatic result(input logic [13:0] d, input bit with_ready);
    i_out_valid = 1'b1;
    i_out_data  = d;
    i_op_ready  = with_ready;
    if (m_cnt < CNT_MAX) m_cnt++;
    res_q.push_back('{data: d, mode: m_mode, cnt: CNT_W'(m_cnt), at: cyc + 1});
    tick();
    i_out_valid = 1'b0;
    i_op_ready  = 1'b0;
    i_out_data  = 14'($urandom);
  endtask

  task automatic wait_bytes(input int budget);
    int n = 0;
    while (byte_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("load_drain_left", 32'(byte_q.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < IMG_N; i++) rom[i] = 8'($urandom);
    i_rst_n     = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_mode  = 4'd0;
    i_op_ready  = 1'b0;
    i_out_valid = 1'b0;
    i_out_data  = 14'd0;
    repeat (3) tick();

    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_op_valid", 32'(o_op_valid), 32'd0);
    check("rst_op_mode", 32'(o_op_mode), 32'd0);
    check("rst_img_ren", 32'(o_img_ren), 32'd0);
    check("rst_img_addr", 32'(o_img_addr), 32'd0);
    check("rst_in_valid", 32'(o_in_valid), 32'd0);
    check("rst_in_data", 32'(o_in_data), 32'd0);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    check("rst_res_count", 32'(o_res_count), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst_n = 1'b1;
    tick();
    check("idle_no_pending", 32'(o_cmd_ready), 32'd0);

    // LOAD at full throughput
    pulse_op_ready();
    check("cmd_ready_pending", 32'(o_cmd_ready), 32'd1);
    send_cmd(OP_LOAD);
    check("busy_issue", 32'(o_busy), 32'd1);
    wait_bytes(5000);
    check("load_burst_span", 32'(last_x - first_x), 32'(IMG_N - 1));
    check("busy_run", 32'(o_busy), 32'd1);
    pulse_op_ready();
    check("busy_after_ready", 32'(o_busy), 32'd0);
    check("ready_after_run", 32'(o_cmd_ready), 32'd1);

    // LOAD with a randomly stalling consumer
    rand_ready = 1'b1;
    send_cmd(OP_LOAD);
    wait_bytes(20000);
    rand_ready = 1'b0;
    pulse_op_ready();

    // DISPLAY returning 32 results
    send_cmd(OP_DISPLAY);
    tick();
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      result(14'($urandom), 1'b0);
    end
    check("display_busy", 32'(o_busy), 32'd1);
    pulse_op_ready();
    check("display_busy_fall", 32'(o_busy), 32'd0);
    tick();
    check("display_count", 32'(o_res_count), 32'd32);

    // Late command, discarded code, coincident result/op-ready
    repeat (10) tick();
    check("pending_held", 32'(o_cmd_ready), 32'd1);
    send_cmd(4'd12);
    check("discard_keeps_pending", 32'(o_cmd_ready), 32'd1);
    check("discard_not_busy", 32'(o_busy), 32'd0);
    send_cmd(OP_MEDIAN);
    tick();
    result(14'($urandom), 1'b0);
    result(14'($urandom), 1'b1);
    send_cmd(OP_SOBEL_NMS);
    tick();
    result(14'($urandom), 1'b0);
    pulse_op_ready();

    // Result counter saturation
    send_cmd(OP_CONV);
    tick();
    for (int i = 0; i < 70; i++) result(14'($urandom), 1'b0);
    pulse_op_ready();
    check("count_saturated", 32'(o_res_count), 32'(CNT_MAX));

    // Randomized op mix, including discarded codes
    for (int k = 0; k < 25; k++) begin
      logic [3:0] mode;
      int nres;
      mode = 4'($urandom_range(1, 15));
      send_cmd(mode);
      if (mode <= OP_SOBEL_NMS) begin
        tick();
        nres = $urandom_range(0, 5);
        for (int i = 0; i < nres; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          result(14'($urandom), (i == nres - 1) && ($urandom_range(0, 1) == 1));
        end
        if (!o_cmd_ready) pulse_op_ready();
      end
    end

    // Silent core after CONV: watchdog fires after TMO idle RUN cycles
    send_cmd(OP_CONV);
    repeat (TMO) tick();
    check("timeout_not_yet", 32'(o_timeout), 32'd0);
    tick();
    check("timeout_set", 32'(o_timeout), 32'd1);
    pulse_op_ready();
    i_cmd_valid = 1'b1;
    i_cmd_mode  = OP_DISPLAY;
    for (int i = 0; i < 5; i++) begin
      check("err_cmd_ready", 32'(o_cmd_ready), 32'd0);
      check("err_in_valid", 32'(o_in_valid), 32'd0);
      tick();
    end
    i_cmd_valid = 1'b0;
    check("timeout_sticky", 32'(o_timeout), 32'd1);

    // Reset out of error, then reset in the middle of a LOAD
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    check("timeout_cleared", 32'(o_timeout), 32'd0);
    pulse_op_ready();
    send_cmd(OP_LOAD);
    repeat (50) tick();
    i_rst_n = 1'b0;
    #1;
    check("midload_rst_ren", 32'(o_img_ren), 32'd0);
    check("midload_rst_valid", 32'(o_in_valid), 32'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_ren", 32'(o_img_ren), 32'd0);
      check("post_rst_valid", 32'(o_in_valid), 32'd0);
    end

    repeat (3) tick();
    check("op_queue_empty", 32'(op_q.size()), 32'd0);
    check("res_queue_empty", 32'(res_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_host_sequencer.md
Name: core_host_sequencer

Overview:
- Host-side initiator for the image-processing core's op/load/output protocol.
- Takes queued operation commands from upstream and answers the core's op-ready pulses with one-cycle op_valid/op_mode.
- Streams the 2048-byte image from an image ROM/SRAM on LOAD, and forwards the core's 14-bit results, tagged with the op that produced them.
- Sits between the system controller and the core.

Parameters:
- IMG_BYTES, 2048, bytes streamed per LOAD (8x8x32).
- ADDR_W, 11, image memory address width.
- CNT_W, 16, width of the per-op result counter.
- TIMEOUT_CYCLES, 65535, idle cycles in RUN before the timeout error.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_cmd_valid  in  1  upstream command present
- i_cmd_mode  in  4  op code: 0 LOAD, 1-6 shift/depth, 7 DISPLAY, 8 CONV, 9 MEDIAN, 10 SOBEL_NMS
- o_cmd_ready  out  1  command consumed this cycle when high with i_cmd_valid
- o_img_ren  out  1  image memory read enable
- o_img_addr  out  ADDR_W  image memory address
- i_img_rdata  in  8  read data, valid exactly 1 cycle after o_img_ren
- i_op_ready  in  1  core op-request pulse
- o_op_valid  out  1  op issue strobe
- o_op_mode  out  4  op code issued
- i_in_ready  in  1  core accepts load bytes
- o_in_valid  out  1  load byte valid
- o_in_data  out  8  load byte
- i_out_valid  in  1  core result valid
- i_out_data  in  14  core result
- o_res_valid  out  1  registered result valid
- o_res_data  out  14  registered result
- o_res_mode  out  4  op code that produced the result
- o_res_count  out  CNT_W  results received for the current op
- o_busy  out  1  an op is in flight
- o_timeout  out  1  sticky timeout error

Behaviour:
- Reset: i_rst_n asynchronous, active-low; clock i_clk. All outputs reset to 0; state S_IDLE; pending flag 0; prefetch buffer empty.
- Pending flag:
  - Set on any cycle where i_op_ready=1.
  - Cleared on the cycle o_op_valid is driven.
  - i_op_ready while pending is already set is harmless (stays 1).
- o_cmd_ready = (state==S_IDLE) && pending.
- Command accepted (i_cmd_valid && o_cmd_ready):
  - mode 0-10: go to S_ISSUE.
  - mode 11-15: consumed and discarded; state stays S_IDLE; nothing issued.
- S_ISSUE (exactly 1 cycle):
  - o_op_valid=1, o_op_mode=latched mode; o_res_count cleared to 0; o_busy=1.
  - Next state: mode 0 -> S_LOAD, else S_RUN.
  - o_op_valid is never high outside S_ISSUE.
- S_LOAD:
  - Reads addresses 0..IMG_BYTES-1 in order into a 2-entry prefetch FIFO.
  - Issue a read only when (occupancy + reads in flight) < 2.
  - o_in_valid = FIFO non-empty; o_in_data = FIFO head.
  - A byte transfers when o_in_valid && i_in_ready; the FIFO pops on transfer.
  - i_in_ready may drop at any time; data must hold steady and no byte may be lost or duplicated.
  - After transfer IMG_BYTES: o_in_valid=0 the next cycle -> S_RUN.
  - Full-throughput target: 1 byte/cycle when i_in_ready stays high.
- S_RUN:
  - Waits for the core's next i_op_ready, then -> S_IDLE with pending set and o_busy=0.
  - Each i_out_valid: o_res_valid/o_res_data one cycle later, o_res_mode = current op, o_res_count += 1 (saturating at all-ones).
  - i_out_valid and i_op_ready in the same cycle: the result belongs to the current op and is still forwarded.
- Result forwarding is active in every state; results outside S_RUN are still forwarded, tagged with the last issued mode.
- Timeout:
  - Counter runs in S_RUN and S_LOAD; reset on i_op_ready, i_out_valid, or a load transfer.
  - Reaching TIMEOUT_CYCLES: o_timeout=1 (sticky), state S_ERR.
  - S_ERR: o_cmd_ready=0, o_op_valid=0, o_in_valid=0; exits only via reset.
- Reset mid-LOAD: FIFO flushed, address counter cleared, no further reads issued.

Decomposition:
- Shared package: 4-bit op-code constants (OP_LOAD..OP_SOBEL_NMS), IMG_BYTES, state encoding.
- One sub-module: prefetch_fifo2 (2-entry FIFO with read-latency credit tracking) used by S_LOAD.

Test Plan:
- Reset, i_op_ready pulse, LOAD command, i_in_ready held 1 -> o_op_valid 1 cycle with mode 0; 2048 bytes delivered in 2048 consecutive cycles, addresses 0..2047, data == ROM[addr].
- LOAD with i_in_ready toggled pseudo-randomly (50%) -> byte sequence identical to the ROM image; no duplicates or gaps; o_in_data stable while stalled.
- Command 7 (DISPLAY); core returns 32 results then i_op_ready -> 32 o_res_valid, each 1 cycle after input, o_res_mode=7, o_res_count=32; o_busy falls with i_op_ready.
- Command arrives 10 cycles after the i_op_ready pulse -> op still issued (pending held); command with mode 12 -> consumed, no o_op_valid, pending still 1.
- i_out_valid coincident with i_op_ready -> result forwarded with the old mode, count incremented, then the next command issues.
- TIMEOUT_CYCLES=100, core silent after CONV issue -> o_timeout=1 at cycle 100; o_cmd_ready stays 0 until reset.
